// File: rtl/missile_hit_detect.sv
// missile_hit_detect: per-frame missile vs. alien-grid collision scan with alive mask and score.
//   Once per synchronised frame_clk rising edge, walks the N_ROWS x N_COLS grid one alien per
//   clock, kills the lowest-index live alien overlapping the missile box and raises Collision
//   until the next frame tick.
//   Optional feature: define ALIEN_RESPAWN_EN to restore a full wave on the first tick after
//   the last alien dies (that tick performs no scan).
// Ports:
//   Clk, Reset_n           system clock, asynchronous active-low reset
//   frame_clk              asynchronous frame clock, synchronised and edge-detected here
//   MissileX/Y, SX/SY      missile box top-left and size (px)
//   MissileLive            1 = missile in flight, 0 = parked (never hits)
//   GridX, GridY           top-left of alien (0,0)
//   Collision              hit flag, held until the next frame tick
//   AliveMask              1 = alien alive, index = row*N_COLS+col
//   HitIndex               index of the last alien killed
//   Score                  running score, saturating at 16'hFFFF
//   AllDead                AliveMask == 0
module missile_hit_detect #(
    parameter int N_ROWS  = 3,
    parameter int N_COLS  = 8,
    parameter int ALIEN_W = 24,
    parameter int ALIEN_H = 16,
    parameter int PITCH_X = 32,
    parameter int PITCH_Y = 24,
    parameter int POINTS  = 10,
    localparam int N      = N_ROWS * N_COLS
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         frame_clk,
    input  logic [9:0]   MissileX,
    input  logic [9:0]   MissileY,
    input  logic [9:0]   MissileSX,
    input  logic [9:0]   MissileSY,
    input  logic         MissileLive,
    input  logic [9:0]   GridX,
    input  logic [9:0]   GridY,
    output logic         Collision,
    output logic [N-1:0] AliveMask,
    output logic [4:0]   HitIndex,
    output logic [15:0]  Score,
    output logic         AllDead
);
    typedef enum logic [1:0] {IDLE, SCAN, KILL} state_t;
    state_t state, state_nxt;
    logic [2:0] fsync;
    logic tick, respawn, clear, start, renew, step, kill, hit, last;
    logic [9:0] mx, my, msx, msy, gx, gy;
    logic [4:0] idx, row, col;
    logic [10:0] ax, ay;
    logic [15:0] score_q;
    logic [16:0] score_sum;

    // fsync[1:0] is the two-flop synchroniser, fsync[2] the previous value for edge detect
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) fsync <= '0;
        else fsync <= {fsync[1:0], frame_clk};
    assign tick = fsync[1] & ~fsync[2];

    assign AllDead = ~|AliveMask;
`ifdef ALIEN_RESPAWN_EN
    assign respawn = AllDead;
`else
    assign respawn = 1'b0;
`endif

    // Box math is 11-bit so far-right/bottom aliens do not wrap at 1023
    assign row = idx / 5'(N_COLS);
    assign col = idx % 5'(N_COLS);
    assign ax = 11'(gx) + 11'(col) * 11'(PITCH_X);
    assign ay = 11'(gy) + 11'(row) * 11'(PITCH_Y);
    assign hit = AliveMask[idx] && (11'(mx) < ax + 11'(ALIEN_W)) && (11'(mx) + 11'(msx) > ax)
              && (11'(my) < ay + 11'(ALIEN_H)) && (11'(my) + 11'(msy) > ay);
    assign last = idx == 5'(N - 1);
    assign score_sum = {1'b0, score_q} + 17'(POINTS);
    assign Score = score_q;

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? SCAN : IDLE;
            SCAN:    state_nxt = hit ? KILL : (last ? IDLE : SCAN);
            KILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clear = (state == IDLE) && tick;
        start = clear && MissileLive && !respawn;
        renew = clear && respawn;
        step  = (state == SCAN) && !hit && !last;
        kill  = state == KILL;
    end

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            Collision <= 1'b0;
            AliveMask <= '1;
            HitIndex  <= '0;
            score_q   <= '0;
            idx       <= '0;
            mx        <= '0;
            my        <= '0;
            msx       <= '0;
            msy       <= '0;
            gx        <= '0;
            gy        <= '0;
        end else begin
            if (clear) Collision <= 1'b0;
            if (renew) AliveMask <= '1;
            if (start) begin
                idx <= '0;
                mx  <= MissileX;
                my  <= MissileY;
                msx <= MissileSX;
                msy <= MissileSY;
                gx  <= GridX;
                gy  <= GridY;
            end
            if (step) idx <= idx + 5'd1;
            if (kill) begin
                AliveMask[idx] <= 1'b0;
                HitIndex       <= idx;
                Collision      <= 1'b1;
                score_q        <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            end
        end
endmodule
